vcm_af_scheduler: RTL

VCM_AF_SCHEDULER -- requirements
Module: vcm_af_scheduler

---
 rtl/vcm_af_scheduler.sv | 128 ++++++++++++
 1 files changed

// File: rtl/vcm_af_scheduler.sv
// Contrast-detect autofocus sweep scheduler.
// Steps the voice-coil lens from STEP_MIN toward STEP_MAX in STEP_INC increments.
// At each position it waits SETTLE_FRAMES frames and then samples one frame's
// sharpness. When the sweep is complete it parks the lens on the sharpest step.
module vcm_af_scheduler #(
  parameter int unsigned STEP_MIN      = 0,
  parameter int unsigned STEP_MAX      = 1023,
  parameter int unsigned STEP_INC      = 64,
  parameter int unsigned SETTLE_FRAMES = 2
) (
  input  logic        CLK_50,
  input  logic        RESET_N,
  input  logic        START,
  input  logic        FRAME_VS,
  input  logic        SHARP_VALID,
  input  logic [31:0] SHARP_SUM,
  input  logic        VCM_ACK,
  output logic        VCM_REQ,
  output logic [15:0] VCM_DATA,
  output logic [9:0]  STEP,
  output logic        BUSY,
  output logic        DONE,
  output logic [9:0]  BEST_STEP,
  output logic [31:0] BEST_SHARP
);

  localparam logic [9:0]  STEP_MIN_W = 10'(STEP_MIN);
  localparam logic [10:0] STEP_MAX_X = 11'(STEP_MAX);
  localparam logic [10:0] STEP_INC_X = 11'(STEP_INC);
  localparam logic [3:0]  SETTLE_W   = 4'(SETTLE_FRAMES);

  typedef enum logic [2:0] {
    ST_IDLE, ST_WRITE, ST_SETTLE, ST_MEASURE, ST_COMPARE, ST_FINAL, ST_DONE
  } state_t;

  state_t      state;
  logic [3:0]  frame_cnt;
  logic [31:0] sharp_lat;
  logic [10:0] next_step;
  logic        better;

  // Candidate next position is formed one bit wider so an overshoot past
  // STEP_MAX is detected instead of silently wrapping to a low step.
  assign next_step = {1'b0, STEP} + STEP_INC_X;
  assign better    = sharp_lat > BEST_SHARP;

  // The DAC word is a fixed re-packing of the registered step.
  assign VCM_DATA = {2'b00, STEP, 4'b0000};

  // Sweep controller: state, handshake, frame counting and best-step tracking.
  always_ff @(posedge CLK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state      <= ST_IDLE;
      frame_cnt  <= 4'd0;
      sharp_lat  <= 32'd0;
      VCM_REQ    <= 1'b0;
      STEP       <= 10'd0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      BEST_STEP  <= 10'd0;
      BEST_SHARP <= 32'd0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (START) begin
            STEP       <= STEP_MIN_W;
            BEST_STEP  <= STEP_MIN_W;
            BEST_SHARP <= 32'd0;
            DONE       <= 1'b0;
            BUSY       <= 1'b1;
            VCM_REQ    <= 1'b1;
            state      <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (VCM_ACK) begin
            VCM_REQ   <= 1'b0;
            frame_cnt <= 4'd0;
            state     <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          // Frames exposed while the lens is still moving are discarded.
          if (FRAME_VS) begin
            frame_cnt <= frame_cnt + 4'd1;
            if (frame_cnt == SETTLE_W - 4'd1) begin
              state <= ST_MEASURE;
            end
          end
        end
        ST_MEASURE: begin
          if (SHARP_VALID) begin
            sharp_lat <= SHARP_SUM;
            state     <= ST_COMPARE;
          end
        end
        ST_COMPARE: begin
          // Strict comparison: on a tie the earlier (lower) step is kept.
          if (better) begin
            BEST_SHARP <= sharp_lat;
            BEST_STEP  <= STEP;
          end
          VCM_REQ <= 1'b1;
          if (next_step <= STEP_MAX_X) begin
            STEP  <= next_step[9:0];
            state <= ST_WRITE;
          end else begin
            // BEST_STEP is updated on this same edge, so forward the winner.
            STEP  <= better ? STEP : BEST_STEP;
            state <= ST_FINAL;
          end
        end
        ST_FINAL: begin
          if (VCM_ACK) begin
            VCM_REQ <= 1'b0;
            DONE    <= 1'b1;
            BUSY    <= 1'b0;
            state   <= ST_DONE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
